// File: rtl/key_event_pkg.sv
// Shared constants and state encoding for the key event generator.
package key_event_pkg;

    localparam int KEY_SET = 0;
    localparam int KEY_RST = 1;
    localparam int KEY_CHK = 2;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 100_000_000;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter and press/long FSM.
module key_channel
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
    localparam logic IDLE = (ACTIVE_LOW != 0);

    logic          s1;
    logic          s2;
    logic          p;
    logic          deb;
    logic          accept;
    key_state_t    state;
    key_state_t    state_nx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic          press_nx;
    logic          rel_nx;
    logic          lng_nx;

    assign p = (ACTIVE_LOW != 0) ? ~s2 : s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= IDLE;
            s2    <= IDLE;
            state <= RELEASED;
            dcnt  <= '0;
            hcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nx;
            dcnt  <= dcnt_nx;
            hcnt  <= hcnt_nx;
            level <= (state_nx != RELEASED);
            press <= press_nx;
            rel   <= rel_nx;
            lng   <= lng_nx;
        end
    end

    // A release accepted in PRESSED wins over the long-hold transition.
    always_comb begin
        state_nx = state;
        dcnt_nx  = '0;
        hcnt_nx  = hcnt;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        lng_nx   = 1'b0;
        deb      = (state != RELEASED);
        accept   = (p != deb) && (dcnt == DMAX);
        if ((p != deb) && !accept) begin
            dcnt_nx = dcnt + 1'b1;
        end
        unique case (state)
            RELEASED: begin
                if (accept) begin
                    state_nx = PRESSED;
                    press_nx = 1'b1;
                    hcnt_nx  = '0;
                end
            end
            PRESSED: begin
                if (accept) begin
                    state_nx = RELEASED;
                    rel_nx   = 1'b1;
                end else if (hcnt == HMAX) begin
                    state_nx = LONG;
                    lng_nx   = 1'b1;
                end else begin
                    hcnt_nx = hcnt + 1'b1;
                end
            end
            LONG: begin
                if (accept) begin
                    state_nx = RELEASED;
                    rel_nx   = 1'b1;
                end
            end
            default: state_nx = RELEASED;
        endcase
    end

endmodule

// File: rtl/key_event_gen.sv
// Debounced press/release/long-press event generator for N_KEYS buttons.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (key_raw[i]),
            .level(key_level[i]),
            .press(key_press[i]),
            .rel  (key_release[i]),
            .lng  (key_long[i])
        );
    end

endmodule
